noc_link_retimer: RTL and testbench
===================================

// Module: noc_link_retimer
// PURPOSE
//  Credit-based router-to-router link stage placed on each mesh port between two axis_router instances.
//  Inserts NUM_PIPELINE register stages on the forward flit path and the same number on the reverse credit path.
//  Carries an upstream-side credit monitor that models downstream buffer occupancy, flags protocol violations
//  and counts completed packets.
// PARAMETERS
//  NUM_PIPELINE       1   register stages per direction; 0 = combinational pass-through, monitor still active
//  FLIT_WIDTH         32  flit payload width
//  DEST_WIDTH         6   destination field width (TDEST_WIDTH + TID_WIDTH)
//  FLIT_BUFFER_DEPTH  4   downstream input-buffer depth = initial credit count
//  PKT_CNT_WIDTH      16  width of the packet counter
// PORTS
//  clk          in   1                noc clock; the only clock
//  rst_n        in   1                asynchronous, active-low reset
//  data_in      in   FLIT_WIDTH       flit from upstream router
//  dest_in      in   DEST_WIDTH       destination from upstream router
//  is_tail_in   in   1                tail marker from upstream router
//  send_in      in   1                flit valid from upstream router
//  credit_out   out  1                credit returned to upstream router
//  data_out     out  FLIT_WIDTH       flit to downstream router
//  dest_out     out  DEST_WIDTH       destination to downstream router
//  is_tail_out  out  1                tail marker to downstream router
//  send_out     out  1                flit valid to downstream router
//  credit_in    in   1                credit from downstream router
//  credit_level out  $clog2(FLIT_BUFFER_DEPTH+1)  modelled credits available to upstream
//  err_overflow out  1                sticky: send_in seen while credit_level==0
//  err_underflow out 1                sticky: credit_out seen while credit_level==FLIT_BUFFER_DEPTH
//  pkt_count    out  PKT_CNT_WIDTH    number of tails accepted on send_in
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - send/is_tail/credit stage bits = 0; data/dest stage regs = 0.
//   - credit_level = FLIT_BUFFER_DEPTH; err_* = 0; pkt_count = 0.
//  Forward path:
//   - {send,is_tail,dest,data}_out equals the input sampled exactly NUM_PIPELINE cycles earlier.
//   - One flit per cycle, no backpressure, no bubbles added or removed.
//  Credit path:
//   - credit_out = credit_in delayed NUM_PIPELINE cycles; every pulse is preserved, none merged.
//  Data/dest may hold stale values when send is 0; only send qualifies them.
//  Credit monitor (acts on the upstream-facing pair send_in/credit_out):
//   - send_in only: level-1. credit_out only: level+1. Both in the same cycle: unchanged.
//   - send_in at level 0: err_overflow set; level saturates at 0.
//   - credit_out at level FLIT_BUFFER_DEPTH: err_underflow set; level saturates at max.
//   - Both at level 0: no error, level unchanged.
//   - err_* clear only on reset.
//  Packet counter:
//   - pkt_count+1 on (send_in & is_tail_in); wraps 2^PKT_CNT_WIDTH-1 -> 0.
//  Reset mid-operation: in-flight flits and credits in the stages are discarded.
//  No FSM beyond the counters; latency is exactly NUM_PIPELINE in both directions.
// STRUCTURE
//  noc_link_pkg:
//   - typedef struct packed {logic tail; logic [DEST_WIDTH-1:0] dest; logic [FLIT_WIDTH-1:0] data;} flit_t
//     (parameterised through package params).
//   - Function credit_w(depth) returning $clog2(depth+1).
//  Sub-module noc_shift_stage #(WIDTH, DEPTH):
//   - DEPTH-deep reset-to-0 delay line, pass-through when DEPTH==0.
//   - Instantiated twice: {send,flit_t} forward, credit reverse.
//  The monitor and packet counter are local always_ff blocks.
// TESTING
//  1. NUM_PIPELINE=2; send 1 flit data=0xDEADBEEF dest=0x05 tail=1 at cycle 10
//     -> send_out=1 with the same fields at cycle 12 only.
//  2. credit_in pulses at cycles 20,21,23 -> credit_out pulses at 22,23,25; level returns to 4 after 4 sends
//     and 4 credits.
//  3. 5 back-to-back sends with no credits (depth 4) -> level 4,3,2,1,0; err_overflow=1 from the 5th
//     send onward.
//  4. Level 0 and send_in with credit_out in the same cycle -> level stays 0, err_overflow=0;
//     extra credit at level 4 -> err_underflow=1.
//  5. PKT_CNT_WIDTH=4; 17 single-flit packets -> pkt_count=1; 3-flit packet (tail on 3rd) -> +1 only.
//  6. Assert rst_n mid-stream with 2 flits in flight -> outputs 0 immediately; no flit emerges after
//     release; level=4.

Source files
------------

// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the NoC link retimer.
//   flit_t   : tail/dest/data bundle for the default link geometry
//   credit_w : width of a counter that spans 0..depth inclusive
package noc_link_pkg;

  localparam int NOC_FLIT_WIDTH = 32;
  localparam int NOC_DEST_WIDTH = 6;

  typedef struct packed {
    logic                      tail;
    logic [NOC_DEST_WIDTH-1:0] dest;
    logic [NOC_FLIT_WIDTH-1:0] data;
  } flit_t;

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_shift_stage.sv
// Reset-to-zero delay line.
//   clk, rst_n : clock, async active-low reset
//   d_in       : WIDTH-bit input
//   d_out      : d_in delayed DEPTH cycles (combinational when DEPTH==0)
module noc_shift_stage #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign d_out = d_in;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = d_in;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
      end

      assign d_out = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/noc_link_retimer.sv
// Credit-based router-to-router link retimer.
//   Forward: {send,is_tail,dest,data}_in -> *_out, NUM_PIPELINE cycles later.
//   Reverse: credit_in -> credit_out, NUM_PIPELINE cycles later.
//   Monitor: credit_level models the downstream buffer as seen by the upstream
//            router (send_in consumes, credit_out returns). err_overflow and
//            err_underflow are sticky until reset. pkt_count counts accepted tails.
module noc_link_retimer
  import noc_link_pkg::*;
#(
  parameter int NUM_PIPELINE      = 1,
  parameter int FLIT_WIDTH        = 32,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int PKT_CNT_WIDTH     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [FLIT_WIDTH-1:0]                data_in,
  input  logic [DEST_WIDTH-1:0]                dest_in,
  input  logic                                 is_tail_in,
  input  logic                                 send_in,
  output logic                                 credit_out,
  output logic [FLIT_WIDTH-1:0]                data_out,
  output logic [DEST_WIDTH-1:0]                dest_out,
  output logic                                 is_tail_out,
  output logic                                 send_out,
  input  logic                                 credit_in,
  output logic [credit_w(FLIT_BUFFER_DEPTH)-1:0] credit_level,
  output logic                                 err_overflow,
  output logic                                 err_underflow,
  output logic [PKT_CNT_WIDTH-1:0]             pkt_count
);

  localparam int CW = credit_w(FLIT_BUFFER_DEPTH);
  localparam logic [CW-1:0] LVL_MAX = CW'(FLIT_BUFFER_DEPTH);

  // Link-local flit bundle; module parameters may differ from the package default.
  typedef struct packed {
    logic                  send;
    logic                  tail;
    logic [DEST_WIDTH-1:0] dest;
    logic [FLIT_WIDTH-1:0] data;
  } fwd_t;

  fwd_t fwd_in, fwd_out;

  assign fwd_in = '{send: send_in, tail: is_tail_in, dest: dest_in, data: data_in};

  noc_shift_stage #(.WIDTH($bits(fwd_t)), .DEPTH(NUM_PIPELINE)) u_fwd (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (fwd_in),
    .d_out (fwd_out)
  );

  noc_shift_stage #(.WIDTH(1), .DEPTH(NUM_PIPELINE)) u_crd (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (credit_in),
    .d_out (credit_out)
  );

  assign send_out    = fwd_out.send;
  assign is_tail_out = fwd_out.tail;
  assign dest_out    = fwd_out.dest;
  assign data_out    = fwd_out.data;

  // Credit monitor on the upstream-facing pair. A send and a returned credit
  // in the same cycle cancel, even at level 0, so neither flags an error.
  logic [CW-1:0]            level_q, level_d;
  logic                     ovf_q, ovf_d, unf_q, unf_d;
  logic [PKT_CNT_WIDTH-1:0] pkt_q, pkt_d;

  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case ({send_in, credit_out})
      2'b10: if (level_q == '0)     ovf_d = 1'b1;
             else                   level_d = level_q - 1'b1;
      2'b01: if (level_q == LVL_MAX) unf_d = 1'b1;
             else                   level_d = level_q + 1'b1;
      default: ;
    endcase
  end

  // Counter wraps naturally at 2^PKT_CNT_WIDTH.
  always_comb begin
    pkt_d = pkt_q;
    if (send_in && is_tail_in) pkt_d = pkt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= LVL_MAX;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      pkt_q   <= '0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      pkt_q   <= pkt_d;
    end
  end

  assign credit_level  = level_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign pkt_count     = pkt_q;

endmodule

// File: tb/tb_noc_link_retimer.sv
// Directed bench for noc_link_retimer (NUM_PIPELINE=2, depth 4, 4-bit packet counter).
module tb_noc_link_retimer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in, data_out;
  logic [5:0]  dest_in, dest_out;
  logic        is_tail_in, is_tail_out, send_in, send_out;
  logic        credit_in, credit_out;
  logic [2:0]  credit_level;
  logic        err_overflow, err_underflow;
  logic [3:0]  pkt_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  noc_link_retimer #(
    .NUM_PIPELINE(2), .FLIT_WIDTH(32), .DEST_WIDTH(6),
    .FLIT_BUFFER_DEPTH(4), .PKT_CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .send_out(send_out),
    .credit_in(credit_in),
    .credit_level(credit_level), .err_overflow(err_overflow), .err_underflow(err_underflow),
    .pkt_count(pkt_count)
  );

  typedef struct {
    logic        snd, tl;
    logic [5:0]  dst;
    logic [31:0] dat;
    logic        crd;
    logic        e_so, e_tl;
    logic [5:0]  e_dst;
    logic [31:0] e_dat;
    logic        e_co;
    logic [2:0]  e_lvl;
    logic [3:0]  e_pkt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the capturing edge.
  task automatic cyc(input logic s, input logic t, input logic [5:0] d,
                     input logic [31:0] x, input logic c);
    send_in = s; is_tail_in = t; dest_in = d; data_in = x; credit_in = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    send_in = 0; is_tail_in = 0; dest_in = '0; data_in = '0; credit_in = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // forward flits A..D with credits interleaved; latency 2 both ways
    tbl[0] = '{1,1,6'h05,32'hDEADBEEF,0, 0,0,6'h00,32'h0,       0, 3'd3, 4'd1};
    tbl[1] = '{0,0,6'h00,32'h0,       0, 1,1,6'h05,32'hDEADBEEF,0, 3'd3, 4'd1};
    tbl[2] = '{1,0,6'h2A,32'h12345678,1, 0,0,6'h00,32'h0,       0, 3'd2, 4'd1};
    tbl[3] = '{1,0,6'h11,32'hCAFEF00D,1, 1,0,6'h2A,32'h12345678,1, 3'd1, 4'd1};
    tbl[4] = '{1,1,6'h3F,32'h0,       0, 1,0,6'h11,32'hCAFEF00D,1, 3'd1, 4'd2};
    tbl[5] = '{0,0,6'h00,32'h0,       1, 1,1,6'h3F,32'h0,       0, 3'd2, 4'd2};
    tbl[6] = '{0,0,6'h00,32'h0,       1, 0,0,6'h00,32'h0,       1, 3'd2, 4'd2};
    tbl[7] = '{0,0,6'h00,32'h0,       0, 0,0,6'h00,32'h0,       1, 3'd3, 4'd2};
    tbl[8] = '{0,0,6'h00,32'h0,       0, 0,0,6'h00,32'h0,       0, 3'd4, 4'd2};
    tbl[9] = '{0,0,6'h00,32'h0,       0, 0,0,6'h00,32'h0,       0, 3'd4, 4'd2};

    do_reset();
    chk("rst_send_out", send_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_dest_out", dest_out, 0);
    chk("rst_tail_out", is_tail_out, 0);
    chk("rst_credit_out", credit_out, 0);
    chk("rst_level", credit_level, 4);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_unf", err_underflow, 0);
    chk("rst_pkt", pkt_count, 0);

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].snd, tbl[i].tl, tbl[i].dst, tbl[i].dat, tbl[i].crd);
      chk($sformatf("tbl%0d_send_out", i), send_out, tbl[i].e_so);
      chk($sformatf("tbl%0d_credit_out", i), credit_out, tbl[i].e_co);
      chk($sformatf("tbl%0d_level", i), credit_level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_pkt", i), pkt_count, tbl[i].e_pkt);
      chk($sformatf("tbl%0d_errs", i), {err_overflow, err_underflow}, 0);
      if (tbl[i].e_so) begin
        chk($sformatf("tbl%0d_tail", i), is_tail_out, tbl[i].e_tl);
        chk($sformatf("tbl%0d_dest", i), dest_out, tbl[i].e_dst);
        chk($sformatf("tbl%0d_data", i), data_out, tbl[i].e_dat);
      end
    end

    // 5 sends with no credits: overflow on the 5th
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ovf_level_before_%0d", i), credit_level, 4 - i);
      chk($sformatf("ovf_flag_before_%0d", i), err_overflow, 0);
      cyc(1, 0, 6'h01, i, 0);
    end
    chk("ovf_flag_set", err_overflow, 1);
    chk("ovf_level_sat", credit_level, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_sticky", err_overflow, 1);

    // level 0 with simultaneous send+credit, then underflow
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("bal_level0", credit_level, 0);
    cyc(0, 0, 0, 0, 0);
    chk("bal_credit_out_hi", credit_out, 1);
    cyc(1, 0, 0, 0, 0);
    chk("bal_level_hold", credit_level, 0);
    chk("bal_no_ovf", err_overflow, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("unf_level4", credit_level, 4);
    chk("unf_not_yet", err_underflow, 0);
    cyc(0, 0, 0, 0, 0);
    chk("unf_set", err_underflow, 1);
    chk("unf_level_sat", credit_level, 4);
    cyc(0, 0, 0, 0, 0);
    chk("unf_sticky", err_underflow, 1);
    chk("unf_no_ovf", err_overflow, 0);

    // packet counter wrap with 4-bit width
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1, 1, 0, i, 0);
    chk("pkt_wrap", pkt_count, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("pkt_body", pkt_count, 1);
    cyc(1, 1, 0, 0, 0);
    chk("pkt_tail", pkt_count, 2);
    cyc(0, 1, 0, 0, 0);
    chk("pkt_tail_no_send", pkt_count, 2);

    // reset with two flits and a credit in flight
    do_reset();
    cyc(1, 0, 6'h01, 32'hAAAA0001, 1);
    cyc(1, 0, 6'h02, 32'hBBBB0002, 0);
    chk("mid_send_out_pre", send_out, 1);
    chk("mid_data_pre", data_out, 32'hAAAA0001);
    chk("mid_level_pre", credit_level, 2);
    send_in = 0; is_tail_in = 0; dest_in = '0; data_in = '0; credit_in = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_send_out_rst", send_out, 0);
    chk("mid_data_rst", data_out, 0);
    chk("mid_credit_rst", credit_out, 0);
    chk("mid_level_rst", credit_level, 4);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk($sformatf("mid_post_send_%0d", i), send_out, 0);
      chk($sformatf("mid_post_credit_%0d", i), credit_out, 0);
      chk($sformatf("mid_post_level_%0d", i), credit_level, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
